// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Holds the FSM state encodings and the counter-width helper.
// No logic; imported by serial_add_ctrl.
package serial_add_ctrl_pkg;

    // Binary 2-bit state encoding.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // The bit counter must be at least one bit wide, even for a 1-bit adder.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full adder cell; the only adder in the serial datapath.
// Latency: purely combinational, 0 cycles.
// Backpressure: none, no handshake.
// Ports: i_a, i_b, i_cin operand bits and carry in; o_sum, o_cout results.
module fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB first through one fa cell.
// Latency: done is high WIDTH+1 cycles after the start request; one add per WIDTH+2 cycles.
// Backpressure: start is sampled only in IDLE; requests while busy or done are dropped.
// Ports: clk/rst (async active-high); start, a, b, cin request inputs;
//        busy, done, sum, cout, overflow registered result outputs.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_cout;
    logic             r_ovf;

    logic             w_sum_bit;
    logic             w_carry_out;

    fa u_fa (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum_bit),
        .o_cout (w_carry_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_RUN;
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_carry  <= cin;
                        r_cnt    <= '0;
                        r_sum_sh <= '0;
                        r_cout   <= 1'b0;
                        r_ovf    <= 1'b0;
                    end
                end
                S_RUN: begin
                    // New sum bit enters at the MSB so that after WIDTH shifts
                    // bit 0 of the result has arrived at position 0. Written as
                    // shift/or so it also holds for WIDTH=1.
                    r_sum_sh <= (r_sum_sh >> 1) | (WIDTH'(w_sum_bit) << (WIDTH - 1));
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_carry  <= w_carry_out;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state <= S_DONE;
                        r_cout  <= w_carry_out;
                        // r_carry is still the carry into the MSB on this edge.
                        r_ovf   <= r_carry ^ w_carry_out;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Decodes of the state register only; no input reaches an output
    // without passing through a flop.
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign sum      = r_sum_sh;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  st;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        cin_in;

    wire  [2:0]  busy_v;
    wire  [2:0]  done_v;
    wire  [2:0]  cout_v;
    wire  [2:0]  ovf_v;
    wire  [7:0]  s8;
    wire  [31:0] s32;
    wire  [0:0]  s1;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    // index 0: WIDTH=8, index 1: WIDTH=32, index 2: WIDTH=1
    serial_add_ctrl #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(st[0]), .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in),
        .busy(busy_v[0]), .done(done_v[0]), .sum(s8), .cout(cout_v[0]), .overflow(ovf_v[0]));
    serial_add_ctrl #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst(rst), .start(st[1]), .a(a_in), .b(b_in), .cin(cin_in),
        .busy(busy_v[1]), .done(done_v[1]), .sum(s32), .cout(cout_v[1]), .overflow(ovf_v[1]));
    serial_add_ctrl #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .start(st[2]), .a(a_in[0:0]), .b(b_in[0:0]), .cin(cin_in),
        .busy(busy_v[2]), .done(done_v[2]), .sum(s1), .cout(cout_v[2]), .overflow(ovf_v[2]));

    function automatic int width_of(input int k);
        return (k == 0) ? 8 : ((k == 1) ? 32 : 1);
    endfunction

    function automatic logic [31:0] sum_of(input int k);
        if (k == 0) return {24'b0, s8};
        if (k == 1) return s32;
        return {31'b0, s1};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Reference: plain integer addition, overflow from operand/result sign rule.
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b, input logic c,
                         output logic [31:0] s, output logic co, output logic o);
        logic [63:0] m;
        logic [63:0] tot;
        m   = (64'd1 << w) - 64'd1;
        tot = ({32'b0, a} & m) + ({32'b0, b} & m) + {63'b0, c};
        s   = tot[31:0] & m[31:0];
        co  = tot[w];
        o   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    endtask

    // One full operation on DUT k; returns edges from request to done and busy cycle count.
    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic c,
                          output logic [31:0] s, output logic co, output logic o,
                          output int lat, output int bc);
        int n;
        bit got;
        @(negedge clk);
        a_in = a; b_in = b; cin_in = c; st[k] = 1'b1;
        n = 0; bc = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk); #1;
            st[k] = 1'b0;
            n++;
            if (busy_v[k]) bc++;
            if (done_v[k]) got = 1'b1;
        end
        lat = got ? n : -1;
        s  = sum_of(k);
        co = cout_v[k];
        o  = ovf_v[k];
        @(posedge clk);   // DONE -> IDLE
    endtask

    typedef struct {
        int          k;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        co;
        logic        o;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [31:0] s, es;
        logic        co, o, eco, eo;
        int          lat, bc, dones, first_done, prev, np;
        logic [31:0] cap_s;
        logic        cap_c, cap_o;

        vecs[0] = '{0, 32'h5A, 32'h3C, 1'b0, 32'h96, 1'b0, 1'b1};
        vecs[1] = '{0, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0};
        vecs[2] = '{0, 32'hFF, 32'hFF, 1'b1, 32'hFF, 1'b1, 1'b0};
        vecs[3] = '{0, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1};
        vecs[4] = '{0, 32'hAA, 32'h55, 1'b1, 32'h00, 1'b1, 1'b0};
        vecs[5] = '{2, 32'h1,  32'h1,  1'b1, 32'h1,  1'b1, 1'b0};
        vecs[6] = '{2, 32'h1,  32'h0,  1'b0, 32'h1,  1'b0, 1'b0};
        vecs[7] = '{2, 32'h0,  32'h0,  1'b1, 32'h1,  1'b0, 1'b1};
        vecs[8] = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 1'b1, 1'b0};

        rst = 1'b1; st = 3'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("reset_w%0d", width_of(k)),
                  64'({busy_v[k], done_v[k], cout_v[k], ovf_v[k], sum_of(k)}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].cin, s, co, o, lat, bc);
            check($sformatf("vec%0d_sum", i),  64'(s),  64'(vecs[i].s));
            check($sformatf("vec%0d_cout", i), 64'(co), 64'(vecs[i].co));
            check($sformatf("vec%0d_ovf", i),  64'(o),  64'(vecs[i].o));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(width_of(vecs[i].k) + 1));
            check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(width_of(vecs[i].k)));
        end

        // Start pulse during RUN must be ignored
        @(negedge clk);
        a_in = 32'h80; b_in = 32'h80; cin_in = 1'b0; st[0] = 1'b1;
        dones = 0; first_done = -1; cap_s = '0; cap_c = 1'b0; cap_o = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (i == 1) st[0] = 1'b0;
            if (i == 3) begin a_in = 32'h01; b_in = 32'h01; st[0] = 1'b1; end
            if (i == 4) st[0] = 1'b0;
            if (done_v[0]) begin
                dones++;
                if (dones == 1) begin
                    first_done = i; cap_s = sum_of(0); cap_c = cout_v[0]; cap_o = ovf_v[0];
                end
            end
        end
        check("ignore_done_count", 64'(dones), 64'd1);
        check("ignore_latency", 64'(first_done), 64'd9);
        check("ignore_sum", 64'(cap_s), 64'h00);
        check("ignore_cout", 64'(cap_c), 64'd1);
        check("ignore_ovf", 64'(cap_o), 64'd1);
        check("ignore_sum_held", 64'(sum_of(0)), 64'h00);

        // Asynchronous reset in the 4th RUN cycle
        @(negedge clk);
        a_in = 32'h55; b_in = 32'hAA; cin_in = 1'b0; st[0] = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            st[0] = 1'b0;
        end
        check("busy_before_rst", 64'(busy_v[0]), 64'd1);
        rst = 1'b1;
        #1;
        check("midrun_reset_outputs",
              64'({busy_v[0], done_v[0], cout_v[0], ovf_v[0], sum_of(0)}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(0, 32'h01, 32'h02, 1'b0, s, co, o, lat, bc);
        check("post_rst_sum", 64'(s), 64'h03);
        check("post_rst_latency", 64'(lat), 64'd9);

        // start held high: one result every WIDTH+2 cycles
        @(negedge clk);
        a_in = 32'h12; b_in = 32'h34; cin_in = 1'b1; st[0] = 1'b1;
        prev = -1; np = 0;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk); #1;
            if (done_v[0]) begin
                np++;
                check($sformatf("hold_sum%0d", np), 64'(sum_of(0)), 64'h47);
                if (prev >= 0) check($sformatf("hold_period%0d", np), 64'(i - prev), 64'd10);
                prev = i;
            end
        end
        st[0] = 1'b0;
        check("hold_pulse_count", 64'(np), 64'd4);
        repeat (12) @(posedge clk);

        // Random operands against the reference model
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 1000; j++) begin
                logic [31:0] ra, rb;
                logic        rc;
                ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
                run_op(k, ra, rb, rc, s, co, o, lat, bc);
                model(width_of(k), ra, rb, rc, es, eco, eo);
                check($sformatf("rand_w%0d_%0d_sum", width_of(k), j), 64'(s), 64'(es));
                check($sformatf("rand_w%0d_%0d_cout", width_of(k), j), 64'(co), 64'(eco));
                check($sformatf("rand_w%0d_%0d_ovf", width_of(k), j), 64'(o), 64'(eo));
                check($sformatf("rand_w%0d_%0d_lat", width_of(k), j), 64'(lat), 64'(width_of(k) + 1));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
